signed_display_driver: RTL

SIGNED_DISPLAY_DRIVER -- requirements
Module: signed_display_driver

---
 rtl/signed_display_driver_pkg.sv | 30 +++
 rtl/bcd_to_seg7.sv | 29 ++
 rtl/signed_display_driver.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/signed_display_driver_pkg.sv
// Shared definitions for the seven-segment display blocks: FSM states,
// internal symbol codes held in the display registers, and segment patterns.
package signed_display_driver_pkg;

    typedef enum logic [1:0] {StIdle, StConv, StCommit} state_e;

    // Non-numeric symbols share the 4-bit code space with BCD digits 0-9
    localparam logic [3:0] SYM_MINUS = 4'hA;
    localparam logic [3:0] SYM_E     = 4'hE;
    localparam logic [3:0] SYM_BLANK = 4'hF;

    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110000;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1111011;
    localparam logic [6:0] SEG_MINUS = 7'b0000001;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [6:0] SEG_E     = 7'b1001111;

    function automatic logic [3:0] add3(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational decoder from a display symbol code (BCD digit, minus, E,
// blank) to active-high segments {a,b,c,d,e,f,g}.
module bcd_to_seg7
    import signed_display_driver_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (code)
            4'd0:      seg = SEG_0;
            4'd1:      seg = SEG_1;
            4'd2:      seg = SEG_2;
            4'd3:      seg = SEG_3;
            4'd4:      seg = SEG_4;
            4'd5:      seg = SEG_5;
            4'd6:      seg = SEG_6;
            4'd7:      seg = SEG_7;
            4'd8:      seg = SEG_8;
            4'd9:      seg = SEG_9;
            SYM_MINUS: seg = SEG_MINUS;
            SYM_E:     seg = SEG_E;
            default:   seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/signed_display_driver.sv
// Signed binary to multiplexed seven-segment display: serial double-dabble
// conversion, sign/overflow formatting at commit, free-running digit scanner.
module signed_display_driver
    import signed_display_driver_pkg::*;
#(
    parameter int unsigned W        = 8,
    parameter int unsigned N_DIGITS = 4,
    parameter int unsigned SCAN_DIV = 1000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [W-1:0]        value,
    input  logic                load,
    output logic                busy,
    output logic                done,
    output logic                ovf,
    output logic [N_DIGITS-1:0] an,
    output logic [6:0]          seg
);

    localparam int unsigned BW = 4 * N_DIGITS;
    localparam int unsigned CW = $clog2(W + 1);
    localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IW = $clog2(N_DIGITS);

    state_e        state_q;
    logic          sign_q;
    logic [W-1:0]  mag_q;
    logic [BW-1:0] bcd_q;
    logic [BW-1:0] bcd_adj;
    logic          flag_q;
    logic [CW-1:0] cnt_q;
    logic          done_q;
    logic          ovf_q;
    logic          ovf_d;
    logic [3:0]    disp_q [N_DIGITS];
    logic [3:0]    disp_d [N_DIGITS];
    logic [PW-1:0] presc_q;
    logic [IW-1:0] idx_q;
    logic          nz;
    int            msd;

    always_comb begin
        bcd_adj = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            bcd_adj[4*i +: 4] = add3(bcd_q[4*i +: 4]);
        end
    end

    // Formatting of the finished BCD value into display symbols
    always_comb begin
        nz  = 1'b0;
        msd = 0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (bcd_q[4*i +: 4] != 4'd0) begin
                nz  = 1'b1;
                msd = i;
            end
        end
        ovf_d = flag_q | (sign_q & nz & (msd == int'(N_DIGITS) - 1));
        for (int i = 0; i < N_DIGITS; i++) begin
            if (ovf_d) begin
                disp_d[i] = SYM_E;
            end else if (!nz) begin
                disp_d[i] = (i == 0) ? 4'd0 : SYM_BLANK;
            end else if (i <= msd) begin
                disp_d[i] = bcd_q[4*i +: 4];
            end else if (sign_q && (i == msd + 1)) begin
                disp_d[i] = SYM_MINUS;
            end else begin
                disp_d[i] = SYM_BLANK;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            sign_q  <= 1'b0;
            mag_q   <= '0;
            bcd_q   <= '0;
            flag_q  <= 1'b0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            for (int i = 0; i < N_DIGITS; i++) begin
                disp_q[i] <= SYM_BLANK;
            end
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (load) begin
                        sign_q  <= value[W-1];
                        mag_q   <= value[W-1] ? (~value + W'(1)) : value;
                        bcd_q   <= '0;
                        flag_q  <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= StConv;
                    end
                end
                StConv: begin
                    bcd_q <= {bcd_adj[BW-2:0], mag_q[W-1]};
                    mag_q <= mag_q << 1;
                    if (bcd_adj[BW-1]) begin
                        flag_q <= 1'b1;
                    end
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(W - 1)) begin
                        state_q <= StCommit;
                    end
                end
                StCommit: begin
                    disp_q  <= disp_d;
                    ovf_q   <= ovf_d;
                    done_q  <= 1'b1;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q <= '0;
            idx_q   <= '0;
        end else if (presc_q == PW'(SCAN_DIV - 1)) begin
            presc_q <= '0;
            idx_q   <= (idx_q == IW'(N_DIGITS - 1)) ? '0 : idx_q + IW'(1);
        end else begin
            presc_q <= presc_q + PW'(1);
        end
    end

    assign busy = (state_q != StIdle);
    assign done = done_q;
    assign ovf  = ovf_q;
    assign an   = N_DIGITS'(1) << idx_q;

    bcd_to_seg7 u_bcd_to_seg7 (
        .code (disp_q[idx_q]),
        .seg  (seg)
    );

endmodule
